// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/result bundle between the ID/EXE pipeline and the HI/LO multiply/divide sequencer.
// The master side issues operations and the slave side returns stall, status and results.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [1:0]       hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, op, opa, opb, flush,
    input  stall, busy, done, hilo_we, hi, lo, div0
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output stall, busy, done, hilo_we, hi, lo, div0
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: WIDTH+1 edges from accept to the done pulse (1 for divide-by-zero).
// Holds the pipeline through stall while iterating; start is ignored while busy; flush aborts without write-back.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               sa_q, sb_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   res_hi_q, res_lo_q, hi_q, lo_q;
  logic               res_div0_q, div0_q;

  logic               accept, div_zero, a_neg, b_neg, last, show;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] step_next, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept   = (state_q == IDLE) & bus.start & ~bus.flush;
  assign div_zero = bus.op[1] & (bus.opb == '0);
  assign a_neg    = ~bus.op[0] & bus.opa[WIDTH-1];
  assign b_neg    = ~bus.op[0] & bus.opb[WIDTH-1];
  assign a_mag    = a_neg ? -bus.opa : bus.opa;
  assign b_mag    = b_neg ? -bus.opb : bus.opb;
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));

  // p_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign rem_sh   = p_q[2*WIDTH-1:WIDTH-1];
  assign ge       = (rem_sh >= {1'b0, m_q});
  assign new_rem  = ge ? (rem_sh[WIDTH-1:0] - m_q) : rem_sh[WIDTH-1:0];

  always_comb begin
    step_next = {mul_sum, p_q[WIDTH-1:1]};
    if (is_div_q) begin
      step_next = {new_rem, p_q[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    prod   = (sa_q ^ sb_q) ? -step_next : step_next;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo = (sa_q ^ sb_q) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
      fix_hi = sa_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      m_q        <= '0;
      p_q        <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      res_div0_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div0_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_div_q <= bus.op[1];
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            cnt_q    <= '0;
            if (bus.op[1]) begin
              m_q <= b_mag;
              p_q <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              m_q <= a_mag;
              p_q <= {{WIDTH{1'b0}}, b_mag};
            end
            if (div_zero) begin
              res_hi_q   <= bus.opa;
              res_lo_q   <= '1;
              res_div0_q <= 1'b1;
            end
          end
        end
        CALC: begin
          p_q   <= step_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            res_hi_q   <= fix_hi;
            res_lo_q   <= fix_lo;
            res_div0_q <= 1'b0;
          end
        end
        DONE: begin
          // Commit only a write-back that was not killed, so a flushed DONE leaves hi/lo untouched.
          if (!bus.flush) begin
            hi_q   <= res_hi_q;
            lo_q   <= res_lo_q;
            div0_q <= res_div0_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign show        = (state_q == DONE) & ~bus.flush;
  assign bus.stall   = accept | (state_q == CALC);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = show;
  assign bus.hilo_we = {2{show}};
  assign bus.hi      = show ? res_hi_q : hi_q;
  assign bus.lo      = show ? res_lo_q : lo_q;
  assign bus.div0    = show ? res_div0_q : div0_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed corner cases plus random back-to-back ops against an arithmetic model.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l, output logic d0);
    logic signed [63:0] sp;
    logic [63:0] up;
    int sa, sb;
    d0 = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        h = sp[63:32];
        l = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32];
        l = up[31:0];
      end
      default: begin
        if (b == 0) begin
          h = a; l = '1; d0 = 1'b1;
        end else if (o == 2'b11) begin
          l = a / b; h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = '0;
        end else begin
          sa = a; sb = b;
          l = sa / sb; h = sa % sb;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output bit stall_ok, output logic [W-1:0] h,
                        output logic [W-1:0] l, output logic d0, output logic [1:0] we, output bit to);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b; bus.flush = 1'b0;
    edges = 0; stall_ok = 1'b1; to = 1'b1;
    h = 'x; l = 'x; d0 = 1'bx; we = 'x;
    #1;
    if (bus.stall !== 1'b1) stall_ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      edges++;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        h = bus.hi; l = bus.lo; d0 = bus.div0; we = bus.hilo_we; to = 1'b0;
        bus.start = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      bus.start = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #2;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hilo_we !== 2'b00 || bus.div0 !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl busy=%b done=%b we=%b div0=%b stall=%b expected all zero",
               bus.busy, bus.done, bus.hilo_we, bus.div0, bus.stall);
    end
    vectors++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      miscompares++;
      $display("FAIL reset_hilo hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_mult();
    logic [W-1:0] h, l, eh, el;
    logic d0, ed0;
    logic [1:0] we;
    int edges;
    bit sok, to;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, edges, sok, h, l, d0, we, to);
    model(2'b00, 32'hFFFF_FFFD, 32'd5, eh, el, ed0);
    vectors++;
    if (to || edges != W + 1) begin
      miscompares++;
      $display("FAIL mult_latency edges=%0d timeout=%0d expected %0d", edges, to, W + 1);
    end
    vectors++;
    if (h !== eh || l !== el) begin
      miscompares++;
      $display("FAIL mult_result hi=%h lo=%h expected %h/%h", h, l, eh, el);
    end
    vectors++;
    if (we !== 2'b11 || d0 !== ed0 || !sok) begin
      miscompares++;
      $display("FAIL mult_flags we=%b div0=%b stall_ok=%0d expected 11/%b/1", we, d0, sok, ed0);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.hilo_we !== 2'b00 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse done=%b we=%b busy=%b expected 0/00/0", bus.done, bus.hilo_we, bus.busy);
    end
    vectors++;
    if (bus.hi !== eh || bus.lo !== el) begin
      miscompares++;
      $display("FAIL result_hold hi=%h lo=%h expected %h/%h", bus.hi, bus.lo, eh, el);
    end
    last_hi = eh; last_lo = el;
  endtask

  task automatic test_div();
    logic [1:0]   ops [4] = '{2'b11, 2'b10, 2'b10, 2'b01};
    logic [W-1:0] as  [4] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] h, l, eh, el;
    logic d0, ed0;
    logic [1:0] we;
    int edges;
    bit sok, to;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], edges, sok, h, l, d0, we, to);
      model(ops[i], as[i], bs[i], eh, el, ed0);
      vectors++;
      if (to || edges != W + 1 || !sok) begin
        miscompares++;
        $display("FAIL div_timing case=%0d edges=%0d stall_ok=%0d timeout=%0d expected %0d/1/0", i, edges, sok, to, W + 1);
      end
      vectors++;
      if (h !== eh || l !== el || d0 !== ed0 || we !== 2'b11) begin
        miscompares++;
        $display("FAIL div_result case=%0d hi=%h lo=%h div0=%b we=%b expected %h/%h/%b/11", i, h, l, d0, we, eh, el, ed0);
      end
      last_hi = eh; last_lo = el;
    end
  endtask

  task automatic test_div0();
    logic [W-1:0] h, l, b;
    logic d0;
    logic [1:0] we;
    int edges;
    bit sok, to;
    run_op(2'b11, 32'h0000_1234, 32'd0, edges, sok, h, l, d0, we, to);
    vectors++;
    if (to || edges != 1) begin
      miscompares++;
      $display("FAIL div0_latency edges=%0d timeout=%0d expected 1", edges, to);
    end
    vectors++;
    if (h !== 32'h0000_1234 || l !== 32'hFFFF_FFFF || d0 !== 1'b1 || we !== 2'b11) begin
      miscompares++;
      $display("FAIL div0_result hi=%h lo=%h div0=%b we=%b expected 00001234/ffffffff/1/11", h, l, d0, we);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.div0 !== 1'b1 || bus.hi !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL div0_hold div0=%b hi=%h expected 1/00001234", bus.div0, bus.hi);
    end
    b = $urandom_range(1, 1000);
    run_op(2'b10, $urandom, b, edges, sok, h, l, d0, we, to);
    vectors++;
    if (to || d0 !== 1'b0) begin
      miscompares++;
      $display("FAIL div0_clear div0=%b timeout=%0d expected 0/0", d0, to);
    end
    last_hi = 'x;
    @(posedge clk); #1;
    last_hi = bus.hi === 'x ? '0 : '0;
  endtask

  task automatic test_flush();
    logic [W-1:0] h, l, eh, el, a, b;
    logic d0, ed0;
    logic [1:0] we;
    int edges;
    bit sok, to, seen;
    a = $urandom; b = $urandom;
    run_op(2'b01, a, b, edges, sok, h, l, d0, we, to);
    model(2'b01, a, b, eh, el, ed0);
    last_hi = eh; last_lo = el;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.opa = $urandom; bus.opb = $urandom; bus.flush = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    vectors++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_precondition stall=%b busy=%b expected 1/1", bus.stall, bus.busy);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hilo_we !== 2'b00 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_abort busy=%b done=%b we=%b stall=%b expected 0/0/00/0", bus.busy, bus.done, bus.hilo_we, bus.stall);
    end
    bus.flush = 1'b0;
    #1;
    vectors++;
    if (bus.hi !== last_hi || bus.lo !== last_lo) begin
      miscompares++;
      $display("FAIL flush_keep hi=%h lo=%h expected %h/%h", bus.hi, bus.lo, last_hi, last_lo);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_no_writeback saw done/busy=1 expected none");
    end
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b11; bus.opa = 32'd9; bus.opb = 32'd0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL start_flush_stall stall=%b expected 0", bus.stall);
    end
    @(negedge clk);
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== last_hi) begin
      miscompares++;
      $display("FAIL start_flush_idle busy=%b done=%b hi=%h expected 0/0/%h", bus.busy, bus.done, bus.hi, last_hi);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] h, l;
    logic d0;
    logic [1:0] we;
    int edges;
    bit sok, to;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.opa = $urandom; bus.opb = $urandom;
    @(negedge clk);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hilo_we !== 2'b00 || bus.stall !== 1'b0 ||
        bus.hi !== '0 || bus.lo !== '0 || bus.div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid busy=%b done=%b we=%b stall=%b hi=%h lo=%h div0=%b expected all zero",
               bus.busy, bus.done, bus.hilo_we, bus.stall, bus.hi, bus.lo, bus.div0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, edges, sok, h, l, d0, we, to);
    vectors++;
    if (to || edges != W + 1 || h !== 32'd0 || l !== 32'd42) begin
      miscompares++;
      $display("FAIL reset_recover hi=%h lo=%h edges=%0d timeout=%0d expected 0/2a/%0d", h, l, edges, to, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] h, l, eh, el, a, b;
    logic d0, ed0;
    logic [1:0] we, o;
    int edges, exp_edges;
    bit sok, to;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(o, a, b, edges, sok, h, l, d0, we, to);
      model(o, a, b, eh, el, ed0);
      exp_edges = (o[1] && b == '0) ? 1 : W + 1;
      vectors++;
      if (to || edges != exp_edges || h !== eh || l !== el || d0 !== ed0 || we !== 2'b11 || !sok) begin
        miscompares++;
        $display("FAIL rand_op i=%0d op=%0d a=%h b=%h hi=%h lo=%h div0=%b edges=%0d stall_ok=%0d expected %h/%h/%b/%0d/1",
                 i, o, a, b, h, l, d0, edges, sok, eh, el, ed0, exp_edges);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.opa = '0; bus.opb = '0; bus.flush = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
